// File: rtl/z86_hazard_scoreboard.sv
// z86_hazard_scoreboard
// Tracks in-flight writes of the EX and WB slots and answers DECODE's
// read-after-write hazard query combinationally in the same cycle.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   issue_valid/issue_wmask       DECODE hands an instruction (and its write mask) to EX
//   issue_ready                   EX slot can accept this cycle
//   ex_done, wb_done, flush       EX completion, WB commit, redirect (kills EX only)
//   rd_valid/rd_mask              DECODE query: resources the next instruction reads
//   stall                         query hits an in-flight write
//   busy                          effective in-flight write mask
//   ex_adv                        EX->WB move this cycle
//   stall_count                   saturating count of stalled cycles
//
// reg_mask_t layout (MSB first): gpr[14:7] mem[6] seg[5:2] stackop[1] io[0]
module z86_hazard_scoreboard #(
    // Default follows CONFIG_FORWARDING_REGFILE (0)
    parameter int unsigned FORWARDING = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [14:0] issue_wmask,
    output logic        issue_ready,
    input  logic        ex_done,
    input  logic        wb_done,
    input  logic        flush,
    input  logic        rd_valid,
    input  logic [14:0] rd_mask,
    output logic        stall,
    output logic [14:0] busy,
    output logic        ex_adv,
    output logic [15:0] stall_count
);

    localparam int unsigned MASK_W = 15;
    localparam int unsigned CNT_W  = 16;

    localparam logic [MASK_W-1:0] GPR_BITS    = MASK_W'(15'h7F80);
    // mem and io only block while the writer sits in EX
    localparam logic [MASK_W-1:0] MEM_IO_BITS = MASK_W'(15'h0041);
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(16'hFFFF);

    logic              ex_valid, ex_valid_d;
    logic [MASK_W-1:0] ex_mask, ex_mask_d;
    logic              wb_valid, wb_valid_d;
    logic [MASK_W-1:0] wb_mask, wb_mask_d;
    logic [CNT_W-1:0]  stall_count_d;

    logic              issue_fire;
    logic              wb_fwd_kill;
    logic [MASK_W-1:0] ex_term;
    logic [MASK_W-1:0] wb_term;

    // Query path and handshakes: purely combinational from state and strobes
    always_comb begin
        ex_adv      = ex_valid & ex_done & ~flush & (~wb_valid | wb_done);
        issue_ready = ~ex_valid | ex_adv;
        issue_fire  = issue_valid & issue_ready;
        // Retiring WB GPR results are forwarded to the reader when enabled
        wb_fwd_kill = (FORWARDING != 0) && wb_done;
        ex_term     = ex_valid ? ex_mask : '0;
        wb_term     = wb_valid ? (wb_mask & ~(wb_fwd_kill ? GPR_BITS : '0)) : '0;
        busy        = ex_term | wb_term;
        stall       = rd_valid & (|(rd_mask & busy));
    end

    // Next-state for both slots and the stall counter
    always_comb begin
        ex_valid_d    = ex_valid;
        ex_mask_d     = ex_mask;
        wb_valid_d    = wb_valid;
        wb_mask_d     = wb_mask;
        stall_count_d = stall_count;

        // Flush wins over a same-cycle issue; an issue while not ready is ignored
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue_fire) begin
            ex_valid_d = 1'b1;
            ex_mask_d  = issue_wmask;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end

        if (ex_adv) begin
            wb_valid_d = 1'b1;
            wb_mask_d  = ex_mask & ~MEM_IO_BITS;
        end else if (wb_done) begin
            wb_valid_d = 1'b0;
        end

        if (stall && (stall_count != CNT_MAX)) begin
            stall_count_d = stall_count + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_mask     <= '0;
            wb_valid    <= 1'b0;
            wb_mask     <= '0;
            stall_count <= '0;
        end else begin
            ex_valid    <= ex_valid_d;
            ex_mask     <= ex_mask_d;
            wb_valid    <= wb_valid_d;
            wb_mask     <= wb_mask_d;
            stall_count <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_z86_hazard_scoreboard.sv
// Bench for z86_hazard_scoreboard: one instance per FORWARDING setting driven
// by shared inputs; directed vector table, an async reset sequence, then
// random traffic checked against a pipeline-occupancy model.
module tb_z86_hazard_scoreboard;

    localparam logic [14:0] AX  = 15'h0080;
    localparam logic [14:0] CX  = 15'h0100;
    localparam logic [14:0] MEM = 15'h0040;
    localparam logic [14:0] SS  = 15'h0008;
    localparam logic [14:0] STK = 15'h0002;
    localparam logic [14:0] GPR = 15'h7F80;
    localparam logic [14:0] MIO = 15'h0041;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [14:0] issue_wmask;
    logic        ex_done, wb_done, flush, rd_valid;
    logic [14:0] rd_mask;

    logic        ready0, stall0, adv0, ready1, stall1, adv1;
    logic [14:0] busy0, busy1;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    z86_hazard_scoreboard #(.FORWARDING(0)) dut0 (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wmask(issue_wmask), .issue_ready(ready0),
        .ex_done(ex_done), .wb_done(wb_done), .flush(flush),
        .rd_valid(rd_valid), .rd_mask(rd_mask),
        .stall(stall0), .busy(busy0), .ex_adv(adv0), .stall_count(cnt0)
    );

    z86_hazard_scoreboard #(.FORWARDING(1)) dut1 (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wmask(issue_wmask), .issue_ready(ready1),
        .ex_done(ex_done), .wb_done(wb_done), .flush(flush),
        .rd_valid(rd_valid), .rd_mask(rd_mask),
        .stall(stall1), .busy(busy1), .ex_adv(adv1), .stall_count(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [14:0] im, input logic exd,
                         input logic wbd, input logic fl, input logic rv,
                         input logic [14:0] rm);
        issue_valid = iv;
        issue_wmask = im;
        ex_done     = exd;
        wb_done     = wbd;
        flush       = fl;
        rd_valid    = rv;
        rd_mask     = rm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Directed vectors: one row per cycle, outputs sampled before the rising edge
    typedef struct {
        logic        rst;
        logic        iv;
        logic [14:0] im;
        logic        exd, wbd, fl, rv;
        logic [14:0] rm;
        logic [14:0] b0, b1;
        logic        s0, s1, rdy, adv;
        logic [15:0] c0, c1;
    } vec_t;

    function automatic vec_t row(logic rst, logic iv, logic [14:0] im, logic exd,
                                 logic wbd, logic fl, logic rv, logic [14:0] rm,
                                 logic [14:0] b0, logic [14:0] b1, logic s0,
                                 logic s1, logic rdy, logic adv,
                                 logic [15:0] c0, logic [15:0] c1);
        vec_t v;
        v.rst = rst; v.iv = iv; v.im = im; v.exd = exd; v.wbd = wbd; v.fl = fl;
        v.rv = rv; v.rm = rm; v.b0 = b0; v.b1 = b1; v.s0 = s0; v.s1 = s1;
        v.rdy = rdy; v.adv = adv; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    // Behavioural model: list of in-flight instructions, oldest first
    typedef struct {
        logic [14:0] mask;
        bit          in_wb;
    } inst_t;

    inst_t pipe[$];
    int    mcnt0, mcnt1;

    function automatic logic [14:0] m_busy(bit fwd, logic wbd);
        logic [14:0] b = '0;
        foreach (pipe[i]) begin
            if (!pipe[i].in_wb) b |= pipe[i].mask;
            else if (fwd && wbd) b |= pipe[i].mask & ~MIO & ~GPR;
            else b |= pipe[i].mask & ~MIO;
        end
        return b;
    endfunction

    function automatic bit m_has(bit wb);
        foreach (pipe[i]) if (pipe[i].in_wb == wb) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t tab[$];
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // GPR RAW with single-cycle EX and immediate WB
        tab.push_back(row(1,1,AX,1,1,0,1,AX, 0,0,     0,0, 1,0, 0,0));
        tab.push_back(row(0,0,0, 1,1,0,1,AX, AX,AX,   1,1, 1,1, 0,0));
        tab.push_back(row(0,0,0, 1,1,0,1,AX, AX,0,    1,0, 1,0, 1,1));
        tab.push_back(row(0,0,0, 1,1,0,1,AX, 0,0,     0,0, 1,0, 2,1));
        // mem hazard lasts exactly the EX occupancy, WB held afterwards
        tab.push_back(row(1,1,MEM,0,0,0,1,MEM, 0,0,   0,0, 1,0, 0,0));
        tab.push_back(row(0,0,0, 0,0,0,1,MEM, MEM,MEM,1,1, 0,0, 0,0));
        tab.push_back(row(0,0,0, 0,0,0,1,MEM, MEM,MEM,1,1, 0,0, 1,1));
        tab.push_back(row(0,0,0, 0,0,0,1,MEM, MEM,MEM,1,1, 0,0, 2,2));
        tab.push_back(row(0,0,0, 1,0,0,1,MEM, MEM,MEM,1,1, 1,1, 3,3));
        tab.push_back(row(0,0,0, 0,0,0,1,MEM, 0,0,    0,0, 1,0, 4,4));
        // flush with a same-cycle issue: SS in EX, CX in WB
        tab.push_back(row(1,1,CX,1,0,0,0,0, 0,0,      0,0, 1,0, 0,0));
        tab.push_back(row(0,1,SS,1,0,0,0,0, CX,CX,    0,0, 1,1, 0,0));
        tab.push_back(row(0,1,AX,1,0,1,0,0, CX|SS,CX|SS,0,0, 0,0, 0,0));
        tab.push_back(row(0,0,0, 0,0,0,1,AX|SS, CX,CX,0,0, 1,0, 0,0));
        tab.push_back(row(0,0,0, 0,1,0,1,CX, CX,0,    1,0, 1,0, 0,0));
        // WB backpressure with a stack writer in WB
        tab.push_back(row(1,1,STK,1,0,0,0,0, 0,0,     0,0, 1,0, 0,0));
        tab.push_back(row(0,1,CX,1,0,0,0,0, STK,STK,  0,0, 1,1, 0,0));
        tab.push_back(row(0,0,0, 1,0,0,1,STK, CX|STK,CX|STK,1,1, 0,0, 0,0));
        tab.push_back(row(0,0,0, 1,0,0,1,STK, CX|STK,CX|STK,1,1, 0,0, 1,1));
        tab.push_back(row(0,0,0, 1,1,0,1,STK, CX|STK,CX|STK,1,1, 1,1, 2,2));
        tab.push_back(row(0,0,0, 0,0,0,1,STK, CX,CX,  0,0, 1,0, 3,3));

        foreach (tab[k]) begin
            if (tab[k].rst) do_reset();
            @(negedge clk);
            drive(tab[k].iv, tab[k].im, tab[k].exd, tab[k].wbd, tab[k].fl,
                  tab[k].rv, tab[k].rm);
            #1;
            chk($sformatf("vec%0d busy0", k), 32'(busy0), 32'(tab[k].b0));
            chk($sformatf("vec%0d busy1", k), 32'(busy1), 32'(tab[k].b1));
            chk($sformatf("vec%0d stall0", k), 32'(stall0), 32'(tab[k].s0));
            chk($sformatf("vec%0d stall1", k), 32'(stall1), 32'(tab[k].s1));
            chk($sformatf("vec%0d ready", k), {30'd0, ready1, ready0}, {30'd0, tab[k].rdy, tab[k].rdy});
            chk($sformatf("vec%0d adv", k), {30'd0, adv1, adv0}, {30'd0, tab[k].adv, tab[k].adv});
            chk($sformatf("vec%0d cnt0", k), 32'(cnt0), 32'(tab[k].c0));
            chk($sformatf("vec%0d cnt1", k), 32'(cnt1), 32'(tab[k].c1));
        end

        // Async reset with both slots full and a live stall
        do_reset();
        @(negedge clk); drive(1'b1, STK, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk); drive(1'b1, CX,  1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk); drive(1'b0, '0,  1'b0, 1'b0, 1'b0, 1'b1, STK);
        #1;
        chk("pre_rst stall0", 32'(stall0), 32'd1);
        chk("pre_rst busy0", 32'(busy0), 32'(CX | STK));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst stall", {30'd0, stall1, stall0}, 32'd0);
        chk("rst ready", {30'd0, ready1, ready0}, 32'd3);
        chk("rst adv", {30'd0, adv1, adv0}, 32'd0);
        chk("rst cnt0", 32'(cnt0), 32'd0);
        chk("rst cnt1", 32'(cnt1), 32'd0);
        #1;
        reset = 1'b0;

        // Random traffic against the occupancy model
        do_reset();
        pipe.delete();
        mcnt0 = 0;
        mcnt1 = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [14:0] eb0, eb1;
            bit has_ex, has_wb, m_adv, m_rdy;
            logic iv, exd, wbd, fl, rv;
            logic [14:0] im, rm;
            @(negedge clk);
            iv  = 1'($urandom_range(0, 1));
            im  = 15'($urandom) & 15'($urandom);
            exd = ($urandom_range(0, 3) != 0);
            wbd = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rm  = 15'($urandom) & 15'($urandom) & 15'($urandom);
            drive(iv, im, exd, wbd, fl, rv, rm);
            #1;
            has_ex = m_has(1'b0);
            has_wb = m_has(1'b1);
            m_adv  = has_ex && exd && !fl && (!has_wb || wbd);
            m_rdy  = !has_ex || m_adv;
            eb0    = m_busy(1'b0, wbd);
            eb1    = m_busy(1'b1, wbd);
            chk("rnd busy0", 32'(busy0), 32'(eb0));
            chk("rnd busy1", 32'(busy1), 32'(eb1));
            chk("rnd stall0", 32'(stall0), 32'(rv && ((rm & eb0) != 0)));
            chk("rnd stall1", 32'(stall1), 32'(rv && ((rm & eb1) != 0)));
            chk("rnd adv", {30'd0, adv1, adv0}, {30'd0, m_adv, m_adv});
            chk("rnd ready", {30'd0, ready1, ready0}, {30'd0, m_rdy, m_rdy});
            chk("rnd cnt0", 32'(cnt0), 32'(mcnt0));
            chk("rnd cnt1", 32'(cnt1), 32'(mcnt1));
            // advance the model across the coming rising edge
            if (rv && ((rm & eb0) != 0) && mcnt0 < 65535) mcnt0++;
            if (rv && ((rm & eb1) != 0) && mcnt1 < 65535) mcnt1++;
            if (has_wb && wbd) pipe.pop_front();
            for (int i = pipe.size() - 1; i >= 0; i--) begin
                if (!pipe[i].in_wb) begin
                    if (fl) pipe.delete(i);
                    else if (m_adv) pipe[i].in_wb = 1'b1;
                end
            end
            if (iv && m_rdy && !fl) pipe.push_back('{mask: im, in_wb: 1'b0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
